// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: three-stage pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.
// Optional macro CLA_SATURATE_EN clamps the sum to the signed limit when the result overflows.
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NG = WIDTH / GROUP;

    generate
        if (WIDTH % GROUP != 0 || WIDTH < GROUP || !(GROUP == 2 || GROUP == 4 || GROUP == 8)) begin : g_bad_params
            $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP and GROUP must be 2, 4 or 8");
        end
    endgenerate

    // Carry into position n as a flat sum of products: every generate term ANDed with all propagates above it.
    function automatic logic la(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g, input logic ci, input int n);
        logic r, t;
        t = ci;
        for (int k = 0; k < n; k++) t = t & p[k];
        r = t;
        for (int j = 0; j < n; j++) begin
            t = g[j];
            for (int k = j + 1; k < n; k++) t = t & p[k];
            r = r | t;
        end
        return r;
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_bb;
    logic             w_c0;
    logic             r1_v, r1_c0;
    logic [WIDTH-1:0] r1_p, r1_g;
    logic [NG-1:0]    w_gp, w_gg;
    logic [NG:0]      w_gc;
    logic [WIDTH:0]   w_c;
    logic             r2_v;
    logic [WIDTH:0]   r2_c;
    logic [WIDTH-1:0] r2_p;
    logic [WIDTH-1:0] w_sum, w_res;
    logic             w_ovf;
    logic             r_v, r_cout, r_ovf, r_zero;
    logic [WIDTH-1:0] r_sum;

    assign w_adv    = !r_v || out_ready;
    assign in_ready = w_adv;
    assign w_bb     = sub ? ~b : b;
    assign w_c0     = sub | cin;

    // Stage 1: condition operand B for subtraction and register per-bit propagate/generate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_v  <= 1'b0;
            r1_c0 <= 1'b0;
            r1_p  <= '0;
            r1_g  <= '0;
        end else if (w_adv) begin
            r1_v  <= in_valid;
            r1_c0 <= w_c0;
            r1_p  <= a ^ w_bb;
            r1_g  <= a & w_bb;
        end
    end

    generate
        for (genvar k = 0; k < NG; k++) begin : g_grp
            assign w_gp[k] = &r1_p[k*GROUP +: GROUP];
            assign w_gg[k] = la(r1_p >> (k * GROUP), r1_g >> (k * GROUP), 1'b0, GROUP);
            for (genvar i = 0; i < GROUP; i++) begin : g_bit
                assign w_c[k*GROUP+i] = la(r1_p >> (k * GROUP), r1_g >> (k * GROUP), w_gc[k], i);
            end
        end
        for (genvar k = 0; k <= NG; k++) begin : g_gcar
            assign w_gc[k] = la({{(WIDTH-NG){1'b0}}, w_gp}, {{(WIDTH-NG){1'b0}}, w_gg}, r1_c0, k);
        end
    endgenerate
    assign w_c[WIDTH] = w_gc[NG];

    // Stage 2: register the full carry vector alongside the propagates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_v <= 1'b0;
            r2_c <= '0;
            r2_p <= '0;
        end else if (w_adv) begin
            r2_v <= r1_v;
            r2_c <= w_c;
            r2_p <= r1_p;
        end
    end

    assign w_sum = r2_p ^ r2_c[WIDTH-1:0];
    assign w_ovf = r2_c[WIDTH] ^ r2_c[WIDTH-1];

`ifdef CLA_SATURATE_EN
    logic r1_am, r1_bm, r2_am, r2_bm;

    // Carry the operand sign bits alongside the pipeline to pick the clamp direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_am <= 1'b0;
            r1_bm <= 1'b0;
            r2_am <= 1'b0;
            r2_bm <= 1'b0;
        end else if (w_adv) begin
            r1_am <= a[WIDTH-1];
            r1_bm <= w_bb[WIDTH-1];
            r2_am <= r1_am;
            r2_bm <= r1_bm;
        end
    end

    assign w_res = w_ovf ? {r2_am & r2_bm, {(WIDTH-1){~(r2_am & r2_bm)}}} : w_sum;
`else
    assign w_res = w_sum;
`endif

    // Stage 3: register the final result and flags; zero reflects the possibly clamped sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            r_v    <= r2_v;
            r_sum  <= w_res;
            r_cout <= r2_c[WIDTH];
            r_ovf  <= w_ovf;
            r_zero <= (w_res == '0);
        end
    end

    assign out_valid = r_v;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: randomized and directed checks of cla_addsub_pipe (WIDTH=16, GROUP=4) against an arithmetic model.
module tb_cla_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout, ovf, zero;
    int          n_vec = 0;
    int          n_err = 0;

    cla_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    // Expected {sum, cout, ovf, zero} from plain integer arithmetic.
    function automatic logic [18:0] model(input logic [15:0] ai, input logic [15:0] bi, input logic ci, input logic si);
        logic [15:0] bb, s;
        logic [16:0] t;
        logic        o;
        bb = si ? ~bi : bi;
        t  = {1'b0, ai} + {1'b0, bb} + (si ? 17'd1 : {16'd0, ci});
        s  = t[15:0];
        o  = (ai[15] == bb[15]) && (s[15] != ai[15]);
`ifdef CLA_SATURATE_EN
        if (o) s = ai[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {s, t[16], o, s == 16'd0};
    endfunction

    task automatic run_op(input string nm, input logic [15:0] ai, input logic [15:0] bi, input logic ci, input logic si, input logic [18:0] e);
        @(posedge clk); #1;
        a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready: got %b expected 1", nm, in_ready); end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i < 3) begin
                n_vec++;
                if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_early_valid edge %0d: got %b expected 0", nm, i, out_valid); end
            end
        end
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid: got %b expected 1", nm, out_valid); end
        n_vec++;
        if ({sum, cout, ovf, zero} !== e) begin
            n_err++;
            $display("FAIL %s_result: got sum=%h cout=%b ovf=%b zero=%b expected sum=%h cout=%b ovf=%b zero=%b",
                     nm, sum, cout, ovf, zero, e[18:3], e[2], e[1], e[0]);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, sum, cout, ovf, zero} !== 20'd0) begin n_err++; $display("FAIL reset_outputs: got %h expected 0", {out_valid, sum, cout, ovf, zero}); end
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
`ifdef CLA_SATURATE_EN
        localparam logic [15:0] POS_SAT = 16'h7FFF;
        localparam logic [15:0] NEG_SAT = 16'h8000;
`else
        localparam logic [15:0] POS_SAT = 16'h8000;
        localparam logic [15:0] NEG_SAT = 16'h7FFF;
`endif
        run_op("carry_zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
        run_op("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, {POS_SAT, 1'b0, 1'b1, 1'b0});
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0});
        run_op("neg_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, {NEG_SAT, 1'b1, 1'b1, 1'b0});
        run_op("lookahead",  16'h0FFF, 16'h0001, 1'b1, 1'b0, {16'h1001, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_random_single();
        logic [15:0] ra, rb;
        logic        rc, rs;
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            run_op("rand_single", ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] q[$];
        logic [18:0] held, got, e;
        logic        held_v;
        int          sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (recv < 20 && cyc < 1000) begin
            @(posedge clk); #1;
            in_valid  = (sent < 20) && ($urandom_range(3) != 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            out_ready = ($urandom_range(2) != 0);
            @(negedge clk);
            got = {sum, cout, ovf, zero};
            if (held_v) begin
                n_vec++;
                if (got !== held) begin n_err++; $display("FAIL stall_hold: got %h expected %h", got, held); end
            end
            held_v = 1'b0;
            if (out_valid && !out_ready) begin
                n_vec++;
                if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
                held = got; held_v = 1'b1;
            end
            if (in_valid && in_ready) begin q.push_back(model(a, b, cin, sub)); sent++; end
            if (out_valid && out_ready) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra: got %h expected no result", got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin n_err++; $display("FAIL b2b_result %0d: got %h expected %h", recv, got, e); end
                end
                recv++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (recv != 20 || q.size() != 0) begin n_err++; $display("FAIL b2b_count: got %0d results expected 20 (pending %0d)", recv, q.size()); end
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'h0100 * 16'(i + 1); b = 16'h0011; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || sum !== 16'h0000) begin n_err++; $display("FAIL midreset_clear: got valid=%b sum=%h expected valid=0 sum=0000", out_valid, sum); end
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_stale edge %0d: got %b expected 0", i, out_valid); end
        end
        run_op("after_reset", 16'h1234, 16'h1111, 1'b0, 1'b0, {16'h2345, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_single();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
